seq_codes_pdec_4to16_accum: RTL and testbench
=============================================

Name: seq_codes_pdec_4to16_accum

Overview:
- Inverse of the 16-to-4 priority encoder: rebuilds a 16-bit bit vector from a stream of 4-bit indices, one index per beat.
- The stream is what iterative priority encoding produces: lowest set bit first, each bit cleared after it is reported, so indices arrive in strictly ascending order.
- Each frame is closed by in_last. The block then presents the reconstructed vector, the beat count and an ordering-error flag on a val/rdy output port.
- Sits downstream of sparse-index producers (arbiter grant logs, bitmap compressors) to re-expand their output into dense masks.

Parameters:
- NBITS, 16, width of the reconstructed vector. Must be a power of two, >= 2.
- IDXW, 4, index width. Must equal log2(NBITS).
- CNTW, 5, beat-counter width. Must be >= IDXW+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- in_val  input  1  index beat valid
- in_rdy  output  1  block can accept an index beat
- in_idx  input  IDXW  bit position to set
- in_last  input  1  this beat closes the frame
- out_val  output  1  reconstructed frame valid
- out_rdy  input  1  consumer accepts the frame
- out_vec  output  NBITS  reconstructed bit vector
- out_count  output  CNTW  number of beats in the frame
- out_err  output  1  ordering violation seen in the frame

Behaviour:
- Reset is asynchronous and active-high. While asserted and immediately after release:
  - state = ACCUM
  - out_val = 0, in_rdy = 1
  - out_vec = 0, out_count = 0, out_err = 0
  - internal prev_idx = 0, first = 1
- The FSM has two states, ACCUM and HOLD. in_rdy = (state == ACCUM). out_val = (state == HOLD).
- ACCUM, on an input fire (in_val & in_rdy), registered in the same edge:
  - vec <= vec | (1 << in_idx)
  - count <= count + 1, saturating at 2^CNTW-1 (no wrap-around)
  - if !first and in_idx <= prev_idx: err <= 1. err is sticky for the frame.
  - prev_idx <= in_idx; first <= 0
  - if in_last: state <= HOLD
- ACCUM with in_val = 0: all state holds.
- HOLD:
  - out_vec, out_count and out_err are stable and equal the accumulated values.
  - in_rdy = 0, so in_val, in_idx and in_last are ignored.
  - On an output fire (out_val & out_rdy): vec, count and err clear to 0, first <= 1, state <= ACCUM.
- Latency:
  - out_val rises in the cycle after the in_last beat is accepted.
  - The earliest next input beat is the cycle after the output fire. There is no same-cycle bypass.
  - Throughput is one frame per (beats + 1) cycles when out_rdy is held high.
- Duplicate index: the OR leaves the bit set once. count still increments, and err is set because the duplicate is <= prev_idx.
- An index of NBITS-1 followed by any further beat in the same frame always sets err.
- A frame always holds at least one beat; an empty frame cannot be expressed.
- out_* reflect registered state only. There is no combinational path from in_* to out_*.
- There is no combinational path from out_rdy to in_rdy, or from in_val to out_val.
- Reset asserted mid-frame or mid-HOLD discards the partial or pending frame immediately. out_val drops asynchronously.
- in_idx and in_last are don't-care when in_val = 0. in_idx is never X-propagated into state.

Test Plan:
- Reset, then a single beat idx=0, last=1 -> next cycle out_val=1, out_vec=0x0001, out_count=1, out_err=0; fire out_rdy -> in_rdy=1 next cycle.
- Beats 0, 3, 15 (last on 15), out_rdy=1 -> out_vec=0x8009, out_count=3, out_err=0; output fires the cycle after the last beat.
- Descending beats 5 then 2 (last) -> out_vec=0x0024, out_count=2, out_err=1. Then the duplicate frame 7, 7 (last) -> out_vec=0x0080, out_count=2, out_err=1, confirming err was cleared between frames and set again by the duplicate.
- Backpressure: after the frame 1, 4 (last), hold out_rdy=0 for 3 cycles while driving in_val=1, in_idx=9 -> in_rdy=0 throughout and out_vec=0x0012 stable. Raise out_rdy -> fire, then a frame 9 (last) yields 0x0200.
- Reset pulse after beats 2, 6 (no last) -> out_val=0 and in_rdy=1. A new frame 10 (last) gives out_vec=0x0400, out_count=1, out_err=0.
- Round-trip: random 16-bit vectors (including 0xFFFF) are iteratively priority-encoded into index streams and fed in with random out_rdy stalls -> every out_vec equals its source, out_count equals its popcount, out_err=0.

Source files
------------

// File: rtl/seq_codes_pdec_4to16_accum_if.sv
// Bus bundle for the index-stream to bit-vector accumulator.
// It carries the input index beats and the reconstructed-frame output port.
interface seq_codes_pdec_4to16_accum_if #(
    parameter int unsigned NBITS = 16,
    parameter int unsigned IDXW  = 4,
    parameter int unsigned CNTW  = 5
);
    logic            in_val;
    logic            in_rdy;
    logic [IDXW-1:0] in_idx;
    logic            in_last;
    logic            out_val;
    logic            out_rdy;
    logic [NBITS-1:0] out_vec;
    logic [CNTW-1:0] out_count;
    logic            out_err;

    modport master (
        output in_val, in_idx, in_last, out_rdy,
        input  in_rdy, out_val, out_vec, out_count, out_err
    );

    modport slave (
        input  in_val, in_idx, in_last, out_rdy,
        output in_rdy, out_val, out_vec, out_count, out_err
    );
endinterface

// File: rtl/seq_codes_pdec_4to16_accum.sv
// Rebuilds a dense bit vector from an ascending stream of set-bit indices.
// A frame is closed by in_last, then held on the output port until accepted.
module seq_codes_pdec_4to16_accum #(
    parameter int unsigned NBITS = 16,
    parameter int unsigned IDXW  = 4,
    parameter int unsigned CNTW  = 5
) (
    input logic clk,
    input logic reset,
    seq_codes_pdec_4to16_accum_if.slave bus
);
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] vec_q, vec_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [IDXW-1:0]  prev_q, prev_d;
    logic             first_q, first_d;
    logic             in_rdy_q, out_val_q;

    // Next-state: accumulate beats in ACCUM, clear on output fire in HOLD.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        prev_d  = prev_q;
        first_d = first_q;
        case (state_q)
            ACCUM: begin
                if (bus.in_val) begin
                    vec_d = vec_q | (NBITS'(1) << bus.in_idx);
                    if (cnt_q != {CNTW{1'b1}}) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                    if (!first_q && (bus.in_idx <= prev_q)) begin
                        err_d = 1'b1;
                    end
                    prev_d  = bus.in_idx;
                    first_d = 1'b0;
                    if (bus.in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_rdy) begin
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ACCUM;
            vec_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            prev_q    <= '0;
            first_q   <= 1'b1;
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            prev_q    <= prev_d;
            first_q   <= first_d;
            in_rdy_q  <= (state_d == ACCUM);
            out_val_q <= (state_d == HOLD);
        end
    end

    assign bus.in_rdy    = in_rdy_q;
    assign bus.out_val   = out_val_q;
    assign bus.out_vec   = vec_q;
    assign bus.out_count = cnt_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_seq_codes_pdec_4to16_accum.sv
// Directed and round-trip bench for the index-stream accumulator.
// A frame-level model predicts each output frame from its index list.
module tb_seq_codes_pdec_4to16_accum;
    localparam int unsigned NBITS = 16;
    localparam int unsigned IDXW  = 4;
    localparam int unsigned CNTW  = 5;

    typedef struct {
        logic [NBITS-1:0] vec;
        logic [CNTW-1:0]  cnt;
        logic             err;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_fail;
    logic rdy_rand;
    logic rdy_fixed;
    logic [IDXW-1:0] fidx[$];
    exp_t exp_q[$];

    seq_codes_pdec_4to16_accum_if #(.NBITS(NBITS), .IDXW(IDXW), .CNTW(CNTW)) bus ();

    seq_codes_pdec_4to16_accum #(.NBITS(NBITS), .IDXW(IDXW), .CNTW(CNTW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output consumer: random or fixed ready, updated just after each edge.
    initial begin
        bus.out_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    // Every-cycle compare of the output port against the frame model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rdy_is_not_val", 32'(bus.in_rdy), 32'(!bus.out_val));
                if (bus.out_val) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_frame: out_val=1 with no frame pending, vec=0x%0h", bus.out_vec);
                    end else begin
                        chk("model_vec", 32'(bus.out_vec), 32'(exp_q[0].vec));
                        chk("model_count", 32'(bus.out_count), 32'(exp_q[0].cnt));
                        chk("model_err", 32'(bus.out_err), 32'(exp_q[0].err));
                        if (bus.out_rdy) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic beat(input logic [IDXW-1:0] idx, input logic last);
        int t = 0;
        bus.in_val  = 1'b1;
        bus.in_idx  = idx;
        bus.in_last = last;
        @(negedge clk);
        while (!bus.in_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("beat_accept", 32'(bus.in_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.in_val  = 1'b0;
        bus.in_idx  = '0;
        bus.in_last = 1'b0;
    endtask

    // Model: OR of positions, saturating count, any non-ascending step is an error.
    task automatic send_frame();
        exp_t e;
        e.vec = '0;
        e.cnt = '0;
        e.err = 1'b0;
        for (int i = 0; i < fidx.size(); i++) begin
            e.vec[fidx[i]] = 1'b1;
            if (int'(e.cnt) < (1 << CNTW) - 1) e.cnt = e.cnt + CNTW'(1);
            if (i > 0 && fidx[i] <= fidx[i-1]) e.err = 1'b1;
        end
        exp_q.push_back(e);
        for (int i = 0; i < fidx.size(); i++) begin
            beat(fidx[i], 1'(i == fidx.size() - 1));
        end
    endtask

    task automatic expect_out(input logic [NBITS-1:0] v, input int c, input logic e);
        @(negedge clk);
        chk("lit_out_val", 32'(bus.out_val), 32'd1);
        chk("lit_out_vec", 32'(bus.out_vec), 32'(v));
        chk("lit_out_count", 32'(bus.out_count), 32'(c));
        chk("lit_out_err", 32'(bus.out_err), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_out_val"}, 32'(bus.out_val), 32'd0);
        chk({name, "_in_rdy"}, 32'(bus.in_rdy), 32'd1);
        chk({name, "_out_vec"}, 32'(bus.out_vec), 32'd0);
        chk({name, "_out_count"}, 32'(bus.out_count), 32'd0);
        chk({name, "_out_err"}, 32'(bus.out_err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NBITS-1:0] src;
        n_vec       = 0;
        n_fail      = 0;
        rdy_rand    = 1'b0;
        rdy_fixed   = 1'b1;
        reset       = 1'b1;
        bus.in_val  = 1'b0;
        bus.in_idx  = '0;
        bus.in_last = 1'b0;
        #1;
        check_idle("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset");
        @(posedge clk);
        #1;

        // Single beat frame, then in_rdy returns the cycle after the fire.
        fidx = '{4'd0};
        send_frame();
        expect_out(16'h0001, 1, 1'b0);
        @(negedge clk);
        chk("rdy_after_fire", 32'(bus.in_rdy), 32'd1);
        @(posedge clk);
        #1;

        fidx = '{4'd0, 4'd3, 4'd15};
        send_frame();
        expect_out(16'h8009, 3, 1'b0);

        fidx = '{4'd5, 4'd2};
        send_frame();
        expect_out(16'h0024, 2, 1'b1);
        fidx = '{4'd7, 4'd7};
        send_frame();
        expect_out(16'h0080, 2, 1'b1);
        fidx = '{4'd15, 4'd3};
        send_frame();
        expect_out(16'h8008, 2, 1'b1);

        // Backpressure: output held while input beats are refused.
        rdy_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fidx = '{4'd1, 4'd4};
        send_frame();
        bus.in_val  = 1'b1;
        bus.in_idx  = 4'd9;
        bus.in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_rdy", 32'(bus.in_rdy), 32'd0);
            chk("bp_out_val", 32'(bus.out_val), 32'd1);
            chk("bp_out_vec", 32'(bus.out_vec), 32'h0012);
        end
        @(posedge clk);
        #1;
        bus.in_val  = 1'b0;
        bus.in_last = 1'b0;
        rdy_fixed   = 1'b1;
        wait_drain();
        fidx = '{4'd9};
        send_frame();
        expect_out(16'h0200, 1, 1'b0);

        // Reset mid-frame discards the partial frame.
        beat(4'd2, 1'b0);
        beat(4'd6, 1'b0);
        reset = 1'b1;
        #1;
        check_idle("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        fidx = '{4'd10};
        send_frame();
        expect_out(16'h0400, 1, 1'b0);

        // Count saturation: 33 beats report 31.
        fidx = {};
        for (int i = 0; i < 33; i++) fidx.push_back(IDXW'(i % 16));
        send_frame();
        expect_out(16'hFFFF, 31, 1'b1);

        // Round trip through iterative priority encoding with random stalls.
        rdy_rand = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (n == 0) src = 16'hFFFF;
            else if (n == 1) src = 16'h8000;
            else src = 16'($urandom_range(1, 16'hFFFF));
            fidx = {};
            for (int b = 0; b < NBITS; b++) begin
                if (src[b]) fidx.push_back(IDXW'(b));
            end
            send_frame();
            chk("rt_model_vec", 32'(exp_q[exp_q.size()-1].vec), 32'(src));
            chk("rt_model_cnt", 32'(exp_q[exp_q.size()-1].cnt), 32'($countones(src)));
        end
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
